// File: rtl/mux_pkg.sv
// ============================================================================
// Module : mux_pkg
// Brief  : Shared defaults and saturation helper for the mux2 selector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int c_SIZE_DEFAULT  = 4;
  localparam int c_CNT_W_DEFAULT = 8;

  // Returns a mask of W ones, clipped to 64 bits, used as the counter ceiling.
  function automatic logic [63:0] sat_max(input int unsigned w);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux2_core.sv
// ============================================================================
// Module : mux2_core
// Brief  : Pure combinational SIZE-wide 2:1 select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux2_core
  import mux_pkg::*;
#(
  parameter int SIZE = c_SIZE_DEFAULT
) (
  input  logic [SIZE-1:0] i_data0,
  input  logic [SIZE-1:0] i_data1,
  input  logic            i_sel,
  output logic [SIZE-1:0] o_out
);

  assign o_out = i_sel ? i_data1 : i_data0;

endmodule

`default_nettype wire

// File: rtl/mux2.sv
// ============================================================================
// Module : mux2
// Brief  : 2:1 data selector with registered copy and select-activity monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mux2
  import mux_pkg::*;
#(
  parameter int SIZE  = c_SIZE_DEFAULT,
  parameter int CNT_W = c_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIZE-1:0]  data0,
  input  logic [SIZE-1:0]  data1,
  input  logic             sel,
  input  logic             en,
  input  logic             clr,
  output logic [SIZE-1:0]  out,
  output logic [SIZE-1:0]  out_q,
  output logic             sel_changed,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [SIZE-1:0]  w_out;
  logic             w_sel_diff;
  logic [SIZE-1:0]  r_out_q;
  logic             r_sel_q;
  logic             r_sel_changed;
  logic [CNT_W-1:0] r_switch_cnt;

  mux2_core #(
    .SIZE (SIZE)
  ) u_core (
    .i_data0 (data0),
    .i_data1 (data1),
    .i_sel   (sel),
    .o_out   (w_out)
  );

  assign w_sel_diff = (sel != r_sel_q);

  // Clear re-seeds the sel history with the live sel so no change is seen next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q       <= '0;
      r_sel_q       <= 1'b0;
      r_sel_changed <= 1'b0;
      r_switch_cnt  <= '0;
    end else if (clr) begin
      r_out_q       <= '0;
      r_sel_q       <= sel;
      r_sel_changed <= 1'b0;
      r_switch_cnt  <= '0;
    end else begin
      if (en) r_out_q <= w_out;
      r_sel_q       <= sel;
      r_sel_changed <= w_sel_diff;
      if (w_sel_diff && (r_switch_cnt != c_CNT_MAX)) begin
        r_switch_cnt <= r_switch_cnt + 1'b1;
      end
    end
  end

  assign out         = w_out;
  assign out_q       = r_out_q;
  assign sel_changed = r_sel_changed;
  assign switch_cnt  = r_switch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mux2.sv
// ============================================================================
// Module : tb_mux2
// Brief  : Self-checking bench for mux2 (default and 2-bit counter builds).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mux2;

  localparam int SIZE   = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;

  logic             clk;
  logic             rst_n;
  logic [SIZE-1:0]  data0, data1;
  logic             sel, en, clr;
  logic [SIZE-1:0]  out_a, out_q_a, out_b, out_q_b;
  logic             chg_a, chg_b;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W2-1:0] cnt_b;

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers describing the intended behaviour.
  int m_out_q;
  int m_prev_sel;
  int m_chg;
  int m_cnt_a;
  int m_cnt_b;

  mux2 #(.SIZE(SIZE), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .data0(data0), .data1(data1), .sel(sel),
    .en(en), .clr(clr), .out(out_a), .out_q(out_q_a),
    .sel_changed(chg_a), .switch_cnt(cnt_a)
  );

  mux2 #(.SIZE(SIZE), .CNT_W(CNT_W2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data0(data0), .data1(data1), .sel(sel),
    .en(en), .clr(clr), .out(out_b), .out_q(out_q_b),
    .sel_changed(chg_b), .switch_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out_q    = 0;
      m_prev_sel = 0;
      m_chg      = 0;
      m_cnt_a    = 0;
      m_cnt_b    = 0;
    end else if (clr) begin
      m_out_q    = 0;
      m_prev_sel = int'(sel);
      m_chg      = 0;
      m_cnt_a    = 0;
      m_cnt_b    = 0;
    end else begin
      if (en) m_out_q = sel ? int'(data1) : int'(data0);
      m_chg = (int'(sel) != m_prev_sel) ? 1 : 0;
      if (m_chg == 1) begin
        m_cnt_a = (m_cnt_a + 1 > (1 << CNT_W) - 1)  ? (1 << CNT_W) - 1  : m_cnt_a + 1;
        m_cnt_b = (m_cnt_b + 1 > (1 << CNT_W2) - 1) ? (1 << CNT_W2) - 1 : m_cnt_b + 1;
      end
      m_prev_sel = int'(sel);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_out;
    exp_out = sel ? int'(data1) : int'(data0);
    check({tag, ".out"},      int'(out_a),   exp_out);
    check({tag, ".out_q"},    int'(out_q_a), m_out_q);
    check({tag, ".chg"},      int'(chg_a),   m_chg);
    check({tag, ".cnt"},      int'(cnt_a),   m_cnt_a);
    check({tag, ".out_q_b"},  int'(out_q_b), m_out_q);
    check({tag, ".cnt_b"},    int'(cnt_b),   m_cnt_b);
  endtask

  initial begin
    rst_n = 1'b0;
    data0 = '0; data1 = '0; sel = 1'b0; en = 1'b0; clr = 1'b0;

    #3;
    check("rst.out_q", int'(out_q_a), 0);
    check("rst.chg",   int'(chg_a),   0);
    check("rst.cnt",   int'(cnt_a),   0);
    check("rst.cnt_b", int'(cnt_b),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational select, all inside one half period.
    @(negedge clk);
    data0 = 4'd1; data1 = 4'd2; sel = 1'b0;
    #1 check("comb.sel0", int'(out_a), 1);
    sel = 1'b1;
    #1 check("comb.sel1", int'(out_a), 2);
    sel = 1'b0;
    #1 check("comb.sel0b", int'(out_a), 1);
    data1 = 4'd3; sel = 1'b1;
    #1 check("comb.d1_3", int'(out_a), 3);

    // Registered path.
    @(negedge clk);
    data0 = 4'd5; data1 = 4'd9; sel = 1'b1; en = 1'b1;
    @(negedge clk);
    check("reg.load", int'(out_q_a), 9);
    check_all("reg.load");
    en = 1'b0; sel = 1'b0;
    @(negedge clk);
    check("reg.hold", int'(out_q_a), 9);
    check("reg.out",  int'(out_a),   5);
    check_all("reg.hold");

    // Change tracking from a clean counter.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr.cnt", int'(cnt_a), 0);
    sel = 1'b1;
    @(negedge clk);
    check("tog1.chg", int'(chg_a), 1);
    sel = 1'b0;
    @(negedge clk);
    check("tog2.chg", int'(chg_a), 1);
    check("tog2.cnt", int'(cnt_a), 2);
    repeat (3) begin
      @(negedge clk);
      check("hold.chg", int'(chg_a), 0);
      check("hold.cnt", int'(cnt_a), 2);
    end

    // Saturation on the 2-bit counter build.
    for (int i = 0; i < 5; i++) begin
      sel = ~sel;
      @(negedge clk);
      check_all("sat.step");
    end
    check("sat.cnt_b", int'(cnt_b), 3);
    sel = ~sel;
    @(negedge clk);
    check("sat.hold_b", int'(cnt_b), 3);
    check("sat.cnt_a",  int'(cnt_a), 8);

    // Clear beats enable and a simultaneous sel change.
    en = 1'b1; clr = 1'b1; sel = ~sel; data0 = 4'hA; data1 = 4'hB;
    @(negedge clk);
    check("clr.out_q", int'(out_q_a), 0);
    check("clr.cnt0",  int'(cnt_a),   0);
    check("clr.chg",   int'(chg_a),   0);
    clr = 1'b0; en = 1'b0;
    @(negedge clk);
    check("clr.nospur", int'(chg_a), 0);
    check("clr.cnt1",   int'(cnt_a), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      data0 = SIZE'($urandom);
      data1 = SIZE'($urandom);
      if ($urandom_range(0, 2) == 0) sel = ~sel;
      en  = 1'($urandom);
      clr = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      check_all("rand");
    end

    // Asynchronous reset between edges after activity.
    clr = 1'b0; en = 1'b1; sel = 1'b1; data0 = 4'h6; data1 = 4'hC;
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_q", int'(out_q_a), 0);
    check("arst.cnt",   int'(cnt_a),   0);
    check("arst.chg",   int'(chg_a),   0);
    check("arst.out",   int'(out_a),   6);
    sel = 1'b1;
    #1 check("arst.out1", int'(out_a), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
